// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and sizing helpers for the UART TX arbiter.
package uart_arb_pkg;
    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_LOCKED = 1'b1;
    localparam int MaxReq = 4;

    function automatic int req_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick, first request at or after ptr.
module rr_priority_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] j;
    always_comb begin
        idx = ptr;
        j = '0;
        // Walk offsets downward so the smallest offset from ptr is assigned last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
        any = |req;
        grant = any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking share of one UART TX byte port.
// Optional idle-owner timeout under `define TX_ARB_TIMEOUT_EN (adds timeout_pulse).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NumReq = 2,
`ifdef TX_ARB_TIMEOUT_EN
    parameter int TimeoutCycles = 1_000_000,
`endif
    localparam int ReqIdxWidth = req_idx_width(NumReq)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NumReq*8-1:0]    req_data,
    input  logic [NumReq-1:0]      req_valid,
    input  logic [NumReq-1:0]      req_last,
    output logic [NumReq-1:0]      req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [ReqIdxWidth-1:0] owner,
`ifdef TX_ARB_TIMEOUT_EN
    output logic                   timeout_pulse,
`endif
    output logic                   locked
);
    logic [0:0]             state;
    logic [ReqIdxWidth-1:0] rr_ptr, pick_idx, g, nxt_ptr;
    logic [NumReq-1:0]      pick_grant, sel_oh;
    logic                   pick_any, parked, hold, xfer, last, expire;

    rr_priority_pick #(.N(NumReq), .W(ReqIdxWidth)) u_pick (
        .req(req_valid), .ptr(rr_ptr), .grant(pick_grant), .idx(pick_idx), .any(pick_any)
    );

    // A stalled IDLE grant stays parked on owner so a late arrival cannot steal it.
    always_comb begin
        hold = state == ARB_LOCKED || (parked && req_valid[owner]);
        g = hold ? owner : pick_idx;
        sel_oh = hold ? (NumReq'(1) << owner) : pick_grant;
        tx_valid = reset && (hold ? req_valid[owner] : pick_any);
        tx_data = req_data[int'(g)*8 +: 8];
        req_ready = (reset && tx_ready) ? sel_oh : '0;
        xfer = tx_valid && tx_ready;
        last = req_last[g];
        nxt_ptr = (int'(g) == NumReq - 1) ? '0 : g + 1'b1;
        locked = reset && state == ARB_LOCKED;
    end

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles) + 1;
    logic [CntW-1:0] cnt;
    assign expire = state == ARB_LOCKED && !req_valid[owner] && cnt == CntW'(TimeoutCycles - 1);
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= expire;
            cnt <= (xfer || expire) ? '0
                 : (state == ARB_LOCKED && !req_valid[owner]) ? cnt + 1'b1 : cnt;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ARB_IDLE;
            rr_ptr <= '0;
            owner <= '0;
            parked <= 1'b0;
        end else begin
            parked <= state == ARB_IDLE && tx_valid && !tx_ready;
            if (state == ARB_IDLE && tx_valid) owner <= g;
            if ((xfer && last) || expire) begin
                state <= ARB_IDLE;
                rr_ptr <= nxt_ptr;
            end else if (xfer) begin
                state <= ARB_LOCKED;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven vectors plus directed multi-cycle sequences.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] req_data;
    logic [1:0]  req_valid, req_last, req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, owner, locked;

    logic [23:0] d3;
    logic [2:0]  v3, l3, rdy3;
    logic [7:0]  td3;
    logic        tv3;
    logic [1:0]  own3;
    logic        lk3;
`ifdef TX_ARB_TIMEOUT_EN
    logic tp, tp3;
`endif

    uart_tx_arbiter #(.NumReq(2)
`ifdef TX_ARB_TIMEOUT_EN
        , .TimeoutCycles(16)
`endif
    ) dut (
        .clock(clk), .reset(rst_n), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .owner(owner),
`ifdef TX_ARB_TIMEOUT_EN
        .timeout_pulse(tp),
`endif
        .locked(locked)
    );

    uart_tx_arbiter #(.NumReq(3)
`ifdef TX_ARB_TIMEOUT_EN
        , .TimeoutCycles(16)
`endif
    ) dut3 (
        .clock(clk), .reset(rst_n), .req_data(d3), .req_valid(v3),
        .req_last(l3), .req_ready(rdy3), .tx_data(td3), .tx_valid(tv3),
        .tx_ready(1'b1), .owner(own3),
`ifdef TX_ARB_TIMEOUT_EN
        .timeout_pulse(tp3),
`endif
        .locked(lk3)
    );

    typedef struct {
        logic [1:0] v, l;
        logic       r;
        logic [7:0] d0, d1;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] er;
        logic       el, eo;
    } vec_t;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic r,
                         input logic [7:0] d0, input logic [7:0] d1);
        req_valid = v;
        req_last = l;
        tx_ready = r;
        req_data = {d1, d0};
    endtask

    function automatic vec_t mk(input logic [1:0] v, l, input logic r, input logic [7:0] d0, d1,
                                input logic ev, input logic [7:0] ed, input logic [1:0] er,
                                input logic el, eo);
        vec_t t;
        t.v = v; t.l = l; t.r = r; t.d0 = d0; t.d1 = d1;
        t.ev = ev; t.ed = ed; t.er = er; t.el = el; t.eo = eo;
        return t;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    vec_t tv[13];
    logic [2:0] exp3_rdy[3];
    logic [7:0] exp3_dat[3];

    initial begin
        int stall_err, n, seen;
        // Single-byte round robin, then "ABC" packet with req1 waiting, then an IDLE stall.
        tv[0]  = mk(2'b11, 2'b11, 1, 8'h41, 8'h42, 1, 8'h41, 2'b01, 0, 0);
        tv[1]  = mk(2'b11, 2'b11, 1, 8'h41, 8'h42, 1, 8'h42, 2'b10, 0, 0);
        tv[2]  = mk(2'b11, 2'b11, 1, 8'h41, 8'h42, 1, 8'h41, 2'b01, 0, 1);
        tv[3]  = mk(2'b11, 2'b11, 1, 8'h41, 8'h42, 1, 8'h42, 2'b10, 0, 0);
        tv[4]  = mk(2'b11, 2'b10, 1, 8'h41, 8'h58, 1, 8'h41, 2'b01, 0, 1);
        tv[5]  = mk(2'b11, 2'b10, 1, 8'h42, 8'h58, 1, 8'h42, 2'b01, 1, 0);
        tv[6]  = mk(2'b11, 2'b11, 1, 8'h43, 8'h58, 1, 8'h43, 2'b01, 1, 0);
        tv[7]  = mk(2'b11, 2'b11, 1, 8'h44, 8'h58, 1, 8'h58, 2'b10, 0, 0);
        tv[8]  = mk(2'b10, 2'b11, 0, 8'h44, 8'h59, 1, 8'h59, 2'b00, 0, 1);
        tv[9]  = mk(2'b11, 2'b11, 0, 8'h41, 8'h59, 1, 8'h59, 2'b00, 0, 1);
        tv[10] = mk(2'b11, 2'b11, 1, 8'h41, 8'h59, 1, 8'h59, 2'b10, 0, 1);
        tv[11] = mk(2'b11, 2'b11, 1, 8'h41, 8'h59, 1, 8'h41, 2'b01, 0, 1);
        tv[12] = mk(2'b00, 2'b00, 1, 8'h59, 8'h59, 0, 8'h59, 2'b00, 0, 0);
        exp3_rdy[0] = 3'b100; exp3_rdy[1] = 3'b001; exp3_rdy[2] = 3'b010;
        exp3_dat[0] = 8'h33;  exp3_dat[1] = 8'h31;  exp3_dat[2] = 8'h32;

        rst_n = 1'b0;
        drive(2'b11, 2'b11, 1, 8'h41, 8'h42);
        v3 = '0; l3 = '0; d3 = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_txvalid", c), tx_valid, 0);
            chk($sformatf("rst%0d_ready", c), req_ready, 2'b00);
            chk($sformatf("rst%0d_locked", c), locked, 0);
        end
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tv[i].v, tv[i].l, tv[i].r, tv[i].d0, tv[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d_txvalid", i), tx_valid, tv[i].ev);
            chk($sformatf("v%0d_txdata", i), tx_data, tv[i].ed);
            chk($sformatf("v%0d_ready", i), req_ready, tv[i].er);
            chk($sformatf("v%0d_locked", i), locked, tv[i].el);
            chk($sformatf("v%0d_owner", i), owner, tv[i].eo);
            step();
        end

        // Long transmitter stall: req0 granted from ptr=1, req1 arrives mid-stall.
        drive(2'b01, 2'b11, 0, 8'h60, 8'h61);
        stall_err = 0;
        for (int c = 0; c < 868; c++) begin
            if (c == 400) req_valid = 2'b11;
            @(negedge clk);
            if (tx_data !== 8'h60 || tx_valid !== 1'b1 || req_ready !== 2'b00) stall_err++;
            step();
        end
        chk("stall_hold_errs", stall_err, 0);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_ready", req_ready, 2'b01);
        chk("stall_release_data", tx_data, 8'h60);
        step();
        @(negedge clk);
        chk("after_stall_ready", req_ready, 2'b10);
        chk("after_stall_data", tx_data, 8'h61);
        step();

        // Three requesters: serve req1 to move ptr to 2, then all valid -> 2,0,1.
        drive(2'b00, 2'b00, 1, 8'h00, 8'h00);
        v3 = 3'b010; l3 = 3'b111; d3 = {8'h33, 8'h32, 8'h31};
        @(negedge clk);
        chk("n3_prime_ready", rdy3, 3'b010);
        step();
        v3 = 3'b111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("n3_wrap%0d_ready", k), rdy3, exp3_rdy[k]);
            chk($sformatf("n3_wrap%0d_data", k), td3, exp3_dat[k]);
            step();
        end
        v3 = 3'b000;

        // Owner sends a non-last byte then goes silent.
        drive(2'b11, 2'b10, 1, 8'h41, 8'h42);
        @(negedge clk);
        chk("to_first_data", tx_data, 8'h41);
        step();
        req_valid = 2'b10;
`ifdef TX_ARB_TIMEOUT_EN
        n = 0;
        for (int c = 1; c <= 40 && n == 0; c++) begin
            step();
            if (tp) n = c;
        end
        chk("to_pulse_cycle", n, 16);
        chk("to_unlocked", locked, 0);
        chk("to_req1_ready", req_ready, 2'b10);
        chk("to_req1_data", tx_data, 8'h42);
        step();
        seen = 0;
`else
        seen = 0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ready[1] || !locked) seen++;
            step();
        end
        chk("no_timeout_starve", seen + n, 0);
`endif

        // Reset while locked drops the lock.
        drive(2'b11, 2'b10, 1, 8'h41, 8'h42);
        step();
        @(negedge clk);
        chk("pre_rst_locked", locked, 1);
        step();
        drive(2'b00, 2'b00, 1, 8'h00, 8'h00);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_locked", locked, 0);
        chk("post_rst_owner", owner, 0);
        step();
        drive(2'b10, 2'b11, 1, 8'h00, 8'h55);
        @(negedge clk);
        chk("post_rst_req1_ready", req_ready, 2'b10);
        chk("post_rst_req1_data", tx_data, 8'h55);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
